// File: rtl/sequence_div.sv
// sequence_div: 8-bit by 4-bit unsigned restoring shift-subtract divider.
// One SHIFT/SUB state pair handles each quotient bit. An operation with a
// nonzero divisor reaches DONE 16 edges after the accepting edge. A zero
// divisor goes straight to DONE with a divide-by-zero result.
module sequence_div (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0] r_q;
    logic [7:0] q_q;
    logic [3:0] m_q;
    logic [3:0] cnt_q;

    logic       start;
    logic       last_iter;
    logic       sub_ok;
    logic [4:0] r_diff;

    // A start request only counts while the divider is not busy.
    assign start     = ready && ((state_q == IDLE) || (state_q == DONE));
    assign last_iter = (cnt_q == 4'd7);
    assign sub_ok    = (r_q >= {1'b0, m_q});
    assign r_diff    = r_q - {1'b0, m_q};

    // State register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (ready) begin
                    state_d = (divisor == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT:   state_d = SUB;
            SUB:     state_d = last_iter ? DONE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT, SUB: busy = 1'b1;
            DONE:       done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand load, shift/subtract iterations and result capture.
    // The result registers are written only when DONE is entered, so they
    // never show partial values while the divider is busy.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != 4'd0) begin
                            r_q   <= '0;
                            q_q   <= dividend;
                            m_q   <= divisor;
                            cnt_q <= '0;
                        end else begin
                            quotient  <= '1;
                            remainder <= '1;
                            dbz       <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_q <= {r_q[3:0], q_q[7]};
                    q_q <= {q_q[6:0], 1'b0};
                end
                SUB: begin
                    if (sub_ok) begin
                        r_q <= r_diff;
                    end
                    q_q[0] <= sub_ok;
                    cnt_q  <= cnt_q + 4'd1;
                    // The final quotient bit is formed in this same cycle,
                    // so it is merged directly into the captured result.
                    if (last_iter) begin
                        quotient  <= {q_q[7:1], sub_ok};
                        remainder <= sub_ok ? r_diff[3:0] : r_q[3:0];
                        dbz       <= 1'b0;
                    end
                end
                default: begin
                    r_q <= r_q;
                end
            endcase
        end
    end

endmodule

// File: doc/sequence_div.md
SEQUENCE_DIV -- requirements
Module: sequence_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear_n  input  1  reset; asynchronous, active-low.
REQ-004 ready  input  1  start request; sampled only in IDLE and DONE.
REQ-005 dividend  input  8  unsigned dividend; sampled on the accepting edge.
REQ-006 divisor  input  4  unsigned divisor; sampled on the accepting edge.
REQ-007 quotient  output  8  unsigned quotient, registered.
REQ-008 remainder  output  4  unsigned remainder, registered.
REQ-009 busy  output  1  high in SHIFT and SUB states.
REQ-010 done  output  1  high in DONE state; results valid while high.
REQ-011 dbz  output  1  divide-by-zero flag; valid while done=1.

Function
REQ-012 Algorithm SHALL be restoring shift-subtract division: 5-bit partial remainder R, 8-bit shift register Q, 4-bit divisor register M, 4-bit iteration counter.
REQ-013 States SHALL be IDLE, SHIFT, SUB and DONE, with registered state and combinational next-state decode.
REQ-014 IDLE: with ready=0, hold; with ready=1 and divisor!=0, load Q=dividend, M=divisor, R=0, counter=0, and go to SHIFT.
REQ-015 IDLE or DONE with ready=1 and divisor=0: go to DONE (or stay there); set dbz=1, quotient=8'hFF, remainder=4'hF.
REQ-016 SHIFT: {R,Q} shifts left one bit as a 13-bit unit (R={R[3:0],Q[7]}, Q={Q[6:0],0}), then go to SUB.
REQ-017 SUB: if R >= {0,M}, R=R-{0,M} and Q[0]=1; else R unchanged and Q[0]=0. Counter increments by 1.
REQ-018 SUB: if the counter value before the increment equals 7, go to DONE and load quotient=Q (final bit included) and remainder=R[3:0] with dbz=0; otherwise go to SHIFT.
REQ-019 Latency SHALL be fixed: done rises 16 clock edges after the accepting edge for any nonzero divisor, and 1 edge after it for divisor=0.
REQ-020 ready, dividend and divisor SHALL be ignored while busy=1; input changes during an operation SHALL NOT affect its result.
REQ-021 DONE: hold quotient, remainder and dbz stable while ready=0.
REQ-022 DONE: ready=1 starts a new operation as in REQ-014/015; done falls on that same edge (back-to-back, no IDLE visit required).
REQ-023 quotient, remainder and dbz SHALL change only on entry to DONE or on reset; they SHALL NOT expose intermediate values while busy.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor; R[4] is 0 after every SUB.
REQ-025 busy and done SHALL never be high together, and busy=done=0 in IDLE.

Reset
REQ-026 clear_n=0 SHALL immediately, with no clock, force state=IDLE and set R, Q, M, counter, quotient, remainder, busy, done and dbz to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no partial result is retained.
REQ-028 After clear_n rises, the first edge with ready=1 SHALL be accepted normally.

Verification
REQ-029 dividend=200, divisor=7, ready pulse -> done after 16 edges; quotient=28, remainder=4, dbz=0.
REQ-030 255/1 -> quotient=255, remainder=0; 9/10 -> quotient=0, remainder=9; 254/15 -> quotient=16, remainder=14.
REQ-031 100/0 -> done and dbz=1 one edge after acceptance; quotient=8'hFF, remainder=4'hF.
REQ-032 Start 200/7, change the inputs and pulse ready at edge 5 -> result still 28 r 4 at edge 16; the extra ready is ignored.
REQ-033 Start 200/7, drive clear_n=0 between edges 8 and 9 -> all outputs 0 at once; a following 50/3 gives 16 r 2.
REQ-034 Hold ready=1 continuously in DONE with changing operands -> each result appears every 17 edges; exhaustive 8x4 sweep against a reference model, including divisor=0.
